approx_mult_err_monitor: RTL and testbench

- Streaming consumer for approximate multiplier characterisation. It is the hardware receiving end of an exhaustive A×X sweep.
- Accepts (a, x, approximate product) beats over a valid/ready handshake and recomputes the exact product internally.
- Accumulates accuracy statistics: sample count, exact-match count, error-distance sum, and worst-case error with its operands.
- Sits between a multiplier under test and a register readout.

---
 rtl/approx_mult_err_monitor.sv | 186 ++++++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - approximate multiplier accuracy monitor; optional signed bias accumulator under ERR_BIAS_EN
module approx_mult_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 17,
  parameter int ACC_W = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_a,
  input  logic [W-1:0]     s_x,
  input  logic [2*W-1:0]   s_p,
  input  logic             s_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [W-1:0]     err_max_a,
  output logic [W-1:0]     err_max_x,
  output logic [ACC_W:0]   err_bias
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt;
  logic       accept;

  // start wins over a beat offered in the same cycle
  assign accept = s_valid & s_ready & ~start;

  // state register; drain_cnt counts cycles spent in DRAIN so DONE lands 3 edges after the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN && !start) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  // next state and state-decoded handshake/status outputs
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  ;
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept && s_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd2) state_nxt = DONE;
      end
      DONE:  done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = RUN;
  end

  logic           s1_v;
  logic [W-1:0]   s1_a, s1_x;
  logic [2*W-1:0] s1_p;

  // stage 1: capture accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_x <= '0;
      s1_p <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_a <= s_a;
        s1_x <= s_x;
        s1_p <= s_p;
      end
    end
  end

  logic [2*W-1:0] exact;
  logic [2*W:0]   diff;
  logic [2*W-1:0] abs_diff;

  assign exact    = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_x};
  assign diff     = {1'b0, s1_p} - {1'b0, exact};
  assign abs_diff = diff[2*W] ? (~diff[2*W-1:0] + 1'b1) : diff[2*W-1:0];

  logic           s2_v;
  logic           s2_match;
  logic [W-1:0]   s2_a, s2_x;
  logic [2*W-1:0] s2_abs;
`ifdef ERR_BIAS_EN
  logic [2*W:0]   s2_diff;
`endif

  // stage 2: register exact-product comparison results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_match <= 1'b0;
      s2_a     <= '0;
      s2_x     <= '0;
      s2_abs   <= '0;
`ifdef ERR_BIAS_EN
      s2_diff  <= '0;
`endif
    end else begin
      s2_v     <= s1_v & ~start;
      s2_match <= (s1_p == exact);
      s2_a     <= s1_a;
      s2_x     <= s1_x;
      s2_abs   <= abs_diff;
`ifdef ERR_BIAS_EN
      s2_diff  <= diff;
`endif
    end
  end

  logic [ACC_W:0] sum_ext;
  assign sum_ext = {1'b0, err_sum} + {{(ACC_W+1-2*W){1'b0}}, s2_abs};

  // stage 3: saturating statistics; err_max keeps the first beat on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      match_cnt  <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      err_max_a  <= '0;
      err_max_x  <= '0;
    end else if (start) begin
      sample_cnt <= '0;
      match_cnt  <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      err_max_a  <= '0;
      err_max_x  <= '0;
    end else if (s2_v) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
      if (s2_match && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (s2_abs > err_max) begin
        err_max   <= s2_abs;
        err_max_a <= s2_a;
        err_max_x <= s2_x;
      end
    end
  end

`ifdef ERR_BIAS_EN
  logic [ACC_W:0]   bias_r;
  logic [ACC_W+1:0] bias_sum;

  assign bias_sum = {bias_r[ACC_W], bias_r} + {{(ACC_W+1-2*W){s2_diff[2*W]}}, s2_diff};

  // signed bias accumulator clamped to the signed range of err_bias
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_r <= '0;
    end else if (start) begin
      bias_r <= '0;
    end else if (s2_v) begin
      if (bias_sum[ACC_W+1] != bias_sum[ACC_W])
        bias_r <= bias_sum[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
      else
        bias_r <= bias_sum[ACC_W:0];
    end
  end

  assign err_bias = bias_r;
`else
  assign err_bias = '0;
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - self-checking bench for approx_mult_err_monitor
module tb_approx_mult_err_monitor;
  localparam int W = 8, CNT_W = 17, ACC_W = 33;
`ifdef ERR_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, s_valid, s_last, s_ready, busy, done;
  logic [W-1:0] s_a, s_x, err_max_a, err_max_x;
  logic [2*W-1:0] s_p, err_max;
  logic [CNT_W-1:0] sample_cnt, match_cnt;
  logic [ACC_W-1:0] err_sum;
  logic [ACC_W:0] err_bias;

  approx_mult_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_x(s_x), .s_p(s_p), .s_last(s_last), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .match_cnt(match_cnt), .err_sum(err_sum),
    .err_max(err_max), .err_max_a(err_max_a), .err_max_x(err_max_x), .err_bias(err_bias)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  x;
    logic [15:0] p;
    bit          last;
    int          gap;
  } beat_t;

  typedef struct {
    string tag;
    logic signed [63:0] sample, match, sum, max, ma, mx, bias;
  } exp_t;

  beat_t vecs[$];
  exp_t  exps[$];
  exp_t  sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input longint s, m, su, mx_, a, x, b);
    exp_t e;
    e.tag = tag; e.sample = s; e.match = m; e.sum = su; e.max = mx_; e.ma = a; e.mx = x; e.bias = b;
    return e;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] x, input logic [15:0] p, input bit last, input int gap);
    int n;
    repeat (gap) begin @(negedge clk); s_valid = 1'b0; s_last = 1'b0; end
    @(negedge clk);
    s_valid = 1'b1; s_a = a; s_x = x; s_p = p; s_last = last;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    if (!s_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout actual=s_ready_low expected=s_ready_high");
    end
    @(posedge clk);
  endtask

  task automatic wait_done();
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin s_valid = 1'b0; s_last = 1'b0; end
      n++;
    end while (!done && n < 20);
    e = sb.pop_front();
    chk({e.tag, ":latency"}, n, 4);
    chk({e.tag, ":busy"}, busy, 0);
    chk({e.tag, ":sample_cnt"}, sample_cnt, e.sample);
    chk({e.tag, ":match_cnt"}, match_cnt, e.match);
    chk({e.tag, ":err_sum"}, err_sum, e.sum);
    chk({e.tag, ":err_max"}, err_max, e.max);
    chk({e.tag, ":err_max_a"}, err_max_a, e.ma);
    chk({e.tag, ":err_max_x"}, err_max_x, e.mx);
    chk({e.tag, ":err_bias"}, $signed(err_bias), e.bias);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit first;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_x = '0; s_p = '0;

    vecs.push_back('{8'd2,   8'd3,   16'd6,     1'b0, 0});
    vecs.push_back('{8'd255, 8'd255, 16'd65025, 1'b0, 0});
    vecs.push_back('{8'd0,   8'd7,   16'd0,     1'b0, 0});
    vecs.push_back('{8'd10,  8'd10,  16'd100,   1'b1, 0});
    vecs.push_back('{8'd3,   8'd3,   16'd7,     1'b0, 0});
    vecs.push_back('{8'd3,   8'd3,   16'd11,    1'b0, 0});
    vecs.push_back('{8'd255, 8'd255, 16'd65000, 1'b1, 0});
    vecs.push_back('{8'd3,   8'd3,   16'd7,     1'b0, 2});
    vecs.push_back('{8'd1,   8'd2,   16'd0,     1'b1, 2});
    exps.push_back(mk("exact", 4, 4, 0, 0, 0, 0, 0));
    exps.push_back(mk("error", 3, 0, 29, 25, 255, 255, BIAS_ON ? -25 : 0));
    exps.push_back(mk("tie", 2, 0, 4, 2, 3, 3, BIAS_ON ? -4 : 0));

    repeat (2) @(negedge clk);
    chk("reset:s_ready", s_ready, 0);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    rst = 1'b0;

    // beats offered in IDLE are ignored
    @(negedge clk); s_valid = 1'b1; s_a = 8'd9; s_x = 8'd9; s_p = 16'd1;
    repeat (4) @(negedge clk);
    chk("idle:s_ready", s_ready, 0);
    chk("idle:sample_cnt", sample_cnt, 0);
    s_valid = 1'b0;

    // table-driven runs
    r = 0; first = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (first) begin
        do_start();
        chk({exps[r].tag, ":busy_run"}, busy, 1);
        sb.push_back(exps[r]);
        first = 1'b0;
      end
      send_beat(vecs[i].a, vecs[i].x, vecs[i].p, vecs[i].last, vecs[i].gap);
      if (vecs[i].last) begin
        wait_done();
        r++; first = 1'b1;
      end
    end

    // beats offered in DONE are ignored
    @(negedge clk); s_valid = 1'b1; s_last = 1'b1; s_a = 8'd1; s_x = 8'd1; s_p = 16'd9;
    repeat (4) @(negedge clk);
    chk("done_hold:sample_cnt", sample_cnt, 2);
    chk("done_hold:done", done, 1);
    s_valid = 1'b0; s_last = 1'b0;

    // reset asserted mid-DRAIN clears everything at once
    do_start();
    send_beat(8'd2, 8'd3, 16'd7, 1'b0, 0);
    send_beat(8'd5, 8'd5, 16'd25, 1'b1, 0);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("pre_rst:busy", busy, 1);
    chk("pre_rst:sample_cnt", sample_cnt, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_drain:s_ready", s_ready, 0);
    chk("rst_drain:busy", busy, 0);
    chk("rst_drain:done", done, 0);
    chk("rst_drain:sample_cnt", sample_cnt, 0);
    chk("rst_drain:match_cnt", match_cnt, 0);
    chk("rst_drain:err_sum", err_sum, 0);
    chk("rst_drain:err_max", {err_max, err_max_a, err_max_x}, 0);
    chk("rst_drain:err_bias", $signed(err_bias), 0);
    @(negedge clk); rst = 1'b0;

    // restart mid-run; the beat held during start must not be counted
    do_start();
    send_beat(8'd5, 8'd5, 16'd1, 1'b0, 0);
    send_beat(8'd6, 8'd6, 16'd0, 1'b0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b0;
    sb.push_back(mk("restart", 1, 1, 0, 0, 0, 0, 0));
    send_beat(8'd4, 8'd4, 16'd16, 1'b1, 0);
    wait_done();

    // exhaustive exact sweep
    do_start();
    sb.push_back(mk("sweep", 65536, 65536, 0, 0, 0, 0, 0));
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        send_beat(8'(i), 8'(j), 16'(i * j), (i == 255 && j == 255), 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
